// File: rtl/stream_xbar_pkg.sv
// Shared types and helpers for the stream crossbar:
// scheduler state encoding and one-hot to index conversion.
package stream_xbar_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | 32'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/stream_port_scheduler_rr_priority_pick.sv
// Combinational rotating-priority picker: inputs above last_id win
// lowest-first, then inputs 0..last_id; last_id itself ranks last.
module rr_priority_pick
    import stream_xbar_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_id_i,
    output logic [N-1:0]  pick_o,
    output logic [IW-1:0] pick_id_o,
    output logic          any_o
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] hi_req;

    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i > int'(last_id_i));
        end
    end

    assign hi_req = req_i & hi_mask;

    // x & -x isolates the lowest set bit
    assign pick_o = (|hi_req) ? (hi_req & (~hi_req + N'(1)))
                              : (req_i & (~req_i + N'(1)));

    assign pick_id_o = IW'(onehot_to_idx(32'(pick_o)));
    assign any_o     = |req_i;

endmodule

// File: rtl/stream_port_scheduler.sv
// Per-output-port grant controller: packet-locked round-robin grant,
// tready routing, beat counting and sticky length-error flag.
module stream_port_scheduler
    import stream_xbar_pkg::*;
#(
    parameter int S_DATA_COUNT = 2,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    parameter int MAX_BEATS    = 256,
    parameter int CNT_WIDTH    = $clog2(MAX_BEATS + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_in,
    input  logic [S_DATA_COUNT-1:0] s_valid_i,
    input  logic [S_DATA_COUNT-1:0] s_last_i,
    input  logic                    m_ready_i,
    output logic [S_DATA_COUNT-1:0] s_ready_o,
    output logic                    m_valid_o,
    output logic                    m_last_o,
    output logic [S_DATA_COUNT-1:0] grant_o,
    output logic [T_ID___WIDTH-1:0] id_o,
    output logic                    grant_valid_o,
    output logic [CNT_WIDTH-1:0]    beat_cnt_o,
    output logic                    len_err_o,
    input  logic                    err_clr_i
);

    sched_state_t            state_q, state_d;
    logic [S_DATA_COUNT-1:0] grant_q, grant_d;
    logic [T_ID___WIDTH-1:0] id_q, id_d;
    logic [T_ID___WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic [S_DATA_COUNT-1:0] pick;
    logic [T_ID___WIDTH-1:0] pick_id;
    logic                    any_req;
    logic                    hs;
    logic                    last_hs;
    logic                    load;
    logic                    cnt_full;

    rr_priority_pick #(
        .N  (S_DATA_COUNT),
        .IW (T_ID___WIDTH)
    ) u_pick (
        .req_i     (s_valid_i),
        .last_id_i (ptr_q),
        .pick_o    (pick),
        .pick_id_o (pick_id),
        .any_o     (any_req)
    );

    assign grant_valid_o = (state_q == GRANT);
    assign m_valid_o     = grant_valid_o & s_valid_i[id_q];
    assign m_last_o      = grant_valid_o & s_last_i[id_q];
    assign s_ready_o     = grant_q & {S_DATA_COUNT{m_ready_i}};

    assign hs       = m_valid_o & m_ready_i;
    assign last_hs  = hs & m_last_o;
    assign cnt_full = (cnt_q == CNT_WIDTH'(MAX_BEATS));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                load = any_req;
            end
            GRANT: begin
                if (last_hs) begin
                    if (any_req) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
        endcase

        if (hs && !cnt_full) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        // a new grant starts a fresh packet and moves the pointer
        if (load) begin
            state_d = GRANT;
            grant_d = pick;
            id_d    = pick_id;
            ptr_d   = pick_id;
            cnt_d   = '0;
        end

        if (hs && cnt_full) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= T_ID___WIDTH'(S_DATA_COUNT - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign grant_o    = grant_q;
    assign id_o       = id_q;
    assign beat_cnt_o = cnt_q;
    assign len_err_o  = err_q;

endmodule

// File: tb/tb_stream_port_scheduler.sv
// Directed, table-driven bench for stream_port_scheduler
// with S=4 inputs and a 4-beat packet limit.
module tb_stream_port_scheduler;

    localparam int S  = 4;
    localparam int MB = 4;
    localparam int IW = $clog2(S);
    localparam int CW = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [S-1:0]  s_valid = '0;
    logic [S-1:0]  s_last = '0;
    logic          m_ready = 1'b0;
    logic          err_clr = 1'b0;
    logic [S-1:0]  s_ready;
    logic          m_valid;
    logic          m_last;
    logic [S-1:0]  grant;
    logic [IW-1:0] id;
    logic          grant_valid;
    logic [CW-1:0] beat_cnt;
    logic          len_err;

    int checks = 0;
    int errors = 0;

    stream_port_scheduler #(
        .S_DATA_COUNT (S),
        .MAX_BEATS    (MB)
    ) dut (
        .clk_i         (clk),
        .rst_in        (rst_n),
        .s_valid_i     (s_valid),
        .s_last_i      (s_last),
        .m_ready_i     (m_ready),
        .s_ready_o     (s_ready),
        .m_valid_o     (m_valid),
        .m_last_o      (m_last),
        .grant_o       (grant),
        .id_o          (id),
        .grant_valid_o (grant_valid),
        .beat_cnt_o    (beat_cnt),
        .len_err_o     (len_err),
        .err_clr_i     (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst;
        logic [S-1:0]  v;
        logic [S-1:0]  l;
        logic          r;
        logic          c;
        logic [S-1:0]  g;
        logic [IW-1:0] id;
        logic [CW-1:0] cnt;
        logic          err;
    } vec_t;

    vec_t tbl[$];
    vec_t t;

    function automatic vec_t mk(input logic rst, input logic [S-1:0] v,
                                input logic [S-1:0] l, input logic r,
                                input logic c, input logic [S-1:0] g,
                                input int idv, input int cnt,
                                input logic err);
        vec_t x;
        x.rst = rst;
        x.v   = v;
        x.l   = l;
        x.r   = r;
        x.c   = c;
        x.g   = g;
        x.id  = IW'(idv);
        x.cnt = CW'(cnt);
        x.err = err;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [S-1:0] g,
                           input logic [IW-1:0] idv, input logic [S-1:0] v,
                           input logic [S-1:0] l, input logic r,
                           input logic [CW-1:0] cnt, input logic err);
        chk({tag, " grant"}, 32'(grant), 32'(g));
        chk({tag, " id"}, 32'(id), 32'(idv));
        chk({tag, " grant_valid"}, 32'(grant_valid), 32'(|g));
        chk({tag, " s_ready"}, 32'(s_ready), 32'(g & {S{r}}));
        chk({tag, " m_valid"}, 32'(m_valid), 32'(|(g & v)));
        chk({tag, " m_last"}, 32'(m_last), 32'(|(g & v & l)));
        chk({tag, " beat_cnt"}, 32'(beat_cnt), 32'(cnt));
        chk({tag, " len_err"}, 32'(len_err), 32'(err));
    endtask

    // entered and left at posedge+1; outputs must be zero while held
    task automatic do_reset(input string tag);
        rst_n   = 1'b0;
        s_valid = '1;
        s_last  = '1;
        m_ready = 1'b1;
        err_clr = 1'b0;
        #1;
        chk_all({tag, " rst0"}, '0, '0, '1, '1, 1'b1, '0, 1'b0);
        @(posedge clk);
        #1;
        chk_all({tag, " rst1"}, '0, '0, '1, '1, 1'b1, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // single request after reset
        tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 0, 4'b0100, 2, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 4'b0100, 2, 0, 0));
        // simultaneous requests 1011, two-beat packets: 0,1,3,0
        tbl.push_back(mk(1, 4'b1011, 4'b0000, 1, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1011, 4'b0000, 1, 0, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1011, 4'b0001, 1, 0, 4'b0001, 0, 1, 0));
        tbl.push_back(mk(0, 4'b1011, 4'b0000, 1, 0, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1011, 4'b0010, 1, 0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1011, 4'b0000, 1, 0, 4'b1000, 3, 0, 0));
        tbl.push_back(mk(0, 4'b1011, 4'b1000, 1, 0, 4'b1000, 3, 1, 0));
        tbl.push_back(mk(0, 4'b1011, 4'b0000, 1, 0, 4'b0001, 0, 0, 0));
        // backpressure and valid bubbles on input 1
        tbl.push_back(mk(1, 4'b0010, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 1, 0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 1, 0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 4'b0010, 1, 0, 0));
        // sole requester regranted, then input 0 joins
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 1, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 0, 4'b0100, 2, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 0, 4'b0100, 2, 0, 0));
        tbl.push_back(mk(0, 4'b0101, 4'b0101, 1, 0, 4'b0100, 2, 0, 0));
        tbl.push_back(mk(0, 4'b0101, 4'b0101, 1, 0, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 4'b0100, 2, 0, 0));
        // over-length packet on input 3, clear, set-wins-over-clear
        tbl.push_back(mk(1, 4'b1000, 4'b0000, 1, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 4'b1000, 3, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 4'b1000, 3, 1, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 4'b1000, 3, 2, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 4'b1000, 3, 3, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 4'b1000, 3, 4, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 0, 4'b1000, 3, 4, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 1, 4'b1000, 3, 4, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 1, 1, 4'b1000, 3, 4, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 4'b1000, 3, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b1000, 3, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 4'b1000, 3, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            t = tbl[k];
            if (t.rst) begin
                do_reset($sformatf("v%0d", k));
            end
            s_valid = t.v;
            s_last  = t.l;
            m_ready = t.r;
            err_clr = t.c;
            #1;
            chk_all($sformatf("v%0d", k), t.g, t.id, t.v, t.l, t.r,
                    t.cnt, t.err);
            @(posedge clk);
            #1;
        end

        // reset mid-packet: grant drops without a clock edge,
        // then input 0 regains top priority
        do_reset("mid");
        s_valid = 4'b0110;
        s_last  = 4'b0000;
        m_ready = 1'b1;
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        chk("mid granted", 32'(grant), 32'(4'b0010));
        @(posedge clk);
        #1;
        chk("mid beat2 cnt", 32'(beat_cnt), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid async grant", 32'(grant), 32'(0));
        chk("mid async gv", 32'(grant_valid), 32'(0));
        chk("mid async s_ready", 32'(s_ready), 32'(0));
        chk("mid async m_valid", 32'(m_valid), 32'(0));
        chk("mid async id", 32'(id), 32'(0));
        chk("mid async cnt", 32'(beat_cnt), 32'(0));
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        s_valid = 4'b1011;
        #1;
        chk("mid post-rst idle", 32'(grant), 32'(0));
        @(posedge clk);
        #1;
        chk("mid restart grant", 32'(grant), 32'(4'b0001));
        chk("mid restart id", 32'(id), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
